// File: rtl/decryptor.sv
// decryptor: encryptor with the direction fixed to decrypt.
module decryptor #(
  parameter int MSG_LEN = 22,
  parameter int SEC_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] key      [0:SEC_LEN-1],
  input  logic [7:0] text_in  [0:MSG_LEN-1],
  output logic [7:0] text_out [0:MSG_LEN-1],
  output logic       busy,
  output logic       done
);
  encryptor #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) u (
    .clk(clk), .rst(rst), .start(start), .mode(1'b1), .key(key),
    .text_in(text_in), .text_out(text_out), .busy(busy), .done(done)
  );
endmodule

// File: rtl/encryptor.sv
// encryptor: sequential Vigenere cipher over uppercase ASCII, one byte per clock.
module encryptor #(
  parameter int MSG_LEN = 22,
  parameter int SEC_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] key      [0:SEC_LEN-1],
  input  logic [7:0] text_in  [0:MSG_LEN-1],
  output logic [7:0] text_out [0:MSG_LEN-1],
  output logic       busy,
  output logic       done
);
  localparam int IW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1;
  localparam int KW = SEC_LEN > 1 ? $clog2(SEC_LEN) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [KW-1:0] kidx;
  logic mode_r;
  logic [7:0] key_r [0:SEC_LEN-1];
  logic [7:0] text_r [0:MSG_LEN-1];
  logic [7:0] c, s, sum, res;
  logic last;
  // Decrypt adds 26-s so both directions share one modular add.
  always_comb begin
    c = text_r[idx];
    s = key_r[kidx] % 8'd26;
    sum = (c - 8'd65) + (mode_r ? 8'd26 - s : s);
    res = (c >= 8'd65 && c <= 8'd90) ? 8'd65 + (sum >= 8'd26 ? sum - 8'd26 : sum) : c;
    last = idx == IW'(MSG_LEN - 1);
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      kidx <= '0;
      text_out <= '{default: 8'd0};
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        text_r <= text_in;
        key_r <= key;
        mode_r <= mode;
        text_out <= '{default: 8'd0};
        idx <= '0;
        kidx <= '0;
      end else if (state == RUN) begin
        text_out[idx] <= res;
        idx <= idx + 1'b1;
        kidx <= kidx == KW'(SEC_LEN - 1) ? '0 : kidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_encryptor.sv
// tb_encryptor: randomized and directed checks of encryptor/decryptor against a Vigenere model.
module tb_encryptor;
  localparam int ML = 22;
  localparam int SL = 3;
  typedef logic [7:0] msg_t [0:ML-1];
  typedef logic [7:0] key_t [0:SL-1];
  logic clk = 0, rst = 1, e_start = 0, d_start = 0, mode = 0;
  msg_t text_in, e_out, d_out;
  key_t key;
  logic e_busy, e_done, d_busy, d_done;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  encryptor #(.MSG_LEN(ML), .SEC_LEN(SL)) e (
    .clk(clk), .rst(rst), .start(e_start), .mode(mode), .key(key),
    .text_in(text_in), .text_out(e_out), .busy(e_busy), .done(e_done)
  );
  decryptor #(.MSG_LEN(ML), .SEC_LEN(SL)) d (
    .clk(clk), .rst(rst), .start(d_start), .key(key),
    .text_in(text_in), .text_out(d_out), .busy(d_busy), .done(d_done)
  );
  task automatic chk(input string tag, input logic [8*ML-1:0] got, input logic [8*ML-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [8*ML-1:0] pack(input msg_t m);
    logic [8*ML-1:0] v;
    for (int i = 0; i < ML; i++) v[(ML-1-i)*8 +: 8] = m[i];
    return v;
  endfunction
  function automatic msg_t str2msg(input string s);
    msg_t r;
    for (int i = 0; i < ML; i++) r[i] = i < s.len() ? s[i] : 8'd46;
    return r;
  endfunction
  function automatic msg_t model(input msg_t t, input key_t k, input logic m);
    msg_t r;
    for (int i = 0; i < ML; i++) begin
      int c, s;
      c = int'(t[i]);
      s = int'(k[i % SL]) % 26;
      if (c >= 65 && c <= 90) r[i] = 8'(m ? (c - 65 - s + 26) % 26 + 65 : (c - 65 + s) % 26 + 65);
      else r[i] = t[i];
    end
    return r;
  endfunction
  function automatic msg_t rand_msg();
    msg_t r;
    for (int i = 0; i < ML; i++)
      r[i] = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(65, 90));
    return r;
  endfunction
  function automatic key_t rand_key();
    key_t k;
    for (int i = 0; i < SL; i++) k[i] = 8'($urandom_range(0, 255));
    return k;
  endfunction
  // Starts in the current cycle; poke>0 re-pulses start with fresh inputs at that RUN cycle.
  task automatic run(input logic sel, input msg_t t, input key_t k, input logic m, input int poke, output msg_t r);
    int lat, bc;
    msg_t exp;
    lat = 0;
    bc = 0;
    exp = model(t, k, sel ? 1'b1 : m);
    text_in = t;
    key = k;
    mode = m;
    if (sel) d_start = 1; else e_start = 1;
    @(negedge clk);
    e_start = 0;
    d_start = 0;
    while (!(sel ? d_done : e_done) && lat < 100) begin
      bc += int'(sel ? d_busy : e_busy);
      lat++;
      if (lat == poke) begin
        text_in = rand_msg();
        key = rand_key();
        mode = ~m;
        if (sel) d_start = 1; else e_start = 1;
      end
      @(negedge clk);
      e_start = 0;
      d_start = 0;
    end
    chk("latency", lat, ML);
    chk("busy_cycles", bc, ML);
    chk("busy_at_done", sel ? d_busy : e_busy, 0);
    r = sel ? d_out : e_out;
    chk("text", pack(r), pack(exp));
    @(negedge clk);
    chk("done_one_cycle", sel ? d_done : e_done, 0);
  endtask
  initial begin
    msg_t r1, r2, t;
    key_t k3, k29, k123;
    int dn;
    k3 = '{8'd3, 8'd3, 8'd3};
    k29 = '{8'd29, 8'd29, 8'd29};
    k123 = '{8'd1, 8'd2, 8'd3};
    text_in = str2msg("");
    key = k3;
    repeat (3) @(negedge clk);
    chk("rst_text", pack(e_out), '0);
    chk("rst_busy", e_busy, 0);
    chk("rst_done", e_done, 0);
    rst = 0;
    run(0, str2msg("HELLOTHISISATESTMESSAG"), k3, 0, 0, r1);
    chk("khoor", {r1[0], r1[1], r1[2], r1[3], r1[4]}, 40'h4B484F4F52);
    run(1, r1, k3, 0, 0, r2);
    chk("roundtrip_hello", pack(r2), pack(str2msg("HELLOTHISISATESTMESSAG")));
    run(0, str2msg("XYZ"), k3, 0, 0, r1);
    chk("wrap_enc", {r1[0], r1[1], r1[2]}, "ABC");
    run(1, str2msg("ABC"), k3, 0, 0, r1);
    chk("wrap_dec", {r1[0], r1[1], r1[2]}, "XYZ");
    run(0, str2msg("XYZ"), k29, 0, 0, r1);
    chk("wrap_enc29", {r1[0], r1[1], r1[2]}, "ABC");
    run(0, str2msg("ABC"), k29, 1, 0, r1);
    chk("wrap_dec29", {r1[0], r1[1], r1[2]}, "XYZ");
    run(0, str2msg("AAA"), k123, 0, 0, r1);
    chk("bcd", {r1[0], r1[1], r1[2]}, "BCD");
    run(0, str2msg("a1 "), rand_key(), 0, 0, r1);
    chk("nonletters", {r1[0], r1[1], r1[2]}, {8'd97, 8'd49, 8'd32});
    text_in = rand_msg();
    key = rand_key();
    repeat (5) @(negedge clk);
    chk("idle_hold", pack(e_out), pack(r1));
    text_in = rand_msg();
    e_start = 1;
    @(negedge clk);
    e_start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_text", pack(e_out), '0);
    chk("abort_busy", e_busy, 0);
    chk("abort_done", e_done, 0);
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      dn += int'(e_done);
    end
    chk("abort_no_done", dn, 0);
    run(0, str2msg("HELLOTHISISATESTMESSAG"), k3, 0, 0, r1);
    run(0, rand_msg(), rand_key(), 0, 3, r1);
    run(1, rand_msg(), rand_key(), 0, 7, r1);
    repeat (15) begin
      logic m;
      key_t k;
      t = rand_msg();
      k = rand_key();
      m = 1'($urandom_range(0, 1));
      run(0, t, k, m, 0, r1);
      if (!m) begin
        run(1, r1, k, 0, 0, r2);
        chk("roundtrip", pack(r2), pack(t));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/encryptor.md
ENCRYPTOR -- requirements
Module: encryptor

Interface
REQ-001 SHALL have parameter MSG_LEN, default 22, number of 8-bit characters per message.
REQ-002 SHALL have parameter SEC_LEN, default 3, number of 8-bit key bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to process one message.
REQ-006 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled with start.
REQ-007 SHALL have port key, input, SEC_LEN x 8 bits (unpacked array [0:SEC_LEN-1]): cipher key; sampled with start.
REQ-008 SHALL have port text_in, input, MSG_LEN x 8 bits (unpacked array [0:MSG_LEN-1]): ASCII message; sampled with start.
REQ-009 SHALL have port text_out, output, MSG_LEN x 8 bits (unpacked array [0:MSG_LEN-1]): registered result.
REQ-010 SHALL have port busy, output, 1 bit: high while a message is being processed.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when text_out is complete.
REQ-012 SHALL also be provided as module decryptor, with the same parameters and ports except mode, implemented as encryptor with mode tied to 1.

Function
REQ-013 SHALL implement a Vigenere cipher over uppercase letters: character i uses shift s = key[i mod SEC_LEN] mod 26.
REQ-014 SHALL, in encrypt mode, map an uppercase letter c ('A'..'Z', 65..90) to 'A' + ((c - 'A' + s) mod 26).
REQ-015 SHALL, in decrypt mode, map an uppercase letter c to 'A' + ((c - 'A' - s + 26) mod 26).
REQ-016 SHALL pass every byte outside 65..90 unchanged, in both modes.
REQ-017 SHALL guarantee that decrypt(encrypt(x)) = x for any x and key.
REQ-018 SHALL use a state machine with states IDLE, RUN and DONE.
REQ-019 SHALL, in IDLE with start=1 at clock edge N: latch text_in, key and mode; clear text_out to 0; set index to 0; enter RUN; assert busy.
REQ-020 SHALL, in RUN, at each of edges N+1 through N+MSG_LEN, write exactly one result byte, text_out[index], then increment index.
REQ-021 SHALL, at edge N+MSG_LEN, enter DONE, deassert busy and assert done for exactly one cycle, then return to IDLE.
REQ-022 SHALL ignore start while in RUN or DONE; changes to text_in or key after edge N SHALL NOT affect the current result.
REQ-023 SHALL hold text_out stable in IDLE until the next accepted start.
REQ-024 SHALL, for back-to-back messages, accept a start asserted in the cycle after done.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE, clear text_out to all zeros and set busy=0, done=0 and index=0.
REQ-026 SHALL abort any operation in progress on reset, with no done pulse.
REQ-027 SHALL give rst priority over start in the same cycle.

Verification
REQ-028 SHALL pass this check: encrypt "HELLOTHISISATESTMESSAG" with key {3,3,3} -> text_out begins 75 72 79 79 82 ("KHOOR..."); done rises 22 cycles after start; busy is high for those 22 cycles.
REQ-029 SHALL pass this check: feed the encryptor output into decryptor with key {3,3,3} -> text_out equals "HELLOTHISISATESTMESSAG".
REQ-030 SHALL pass this check: encrypt "XYZ" with key {3,3,3} -> "ABC" (wrap); decrypt "ABC" -> "XYZ"; key {29,29,29} gives identical results.
REQ-031 SHALL pass this check: encrypt "AAA" with key {1,2,3} -> "BCD"; non-letters "a1 " with any key -> unchanged bytes 97 49 32.
REQ-032 SHALL pass this check: assert rst at cycle 5 of RUN -> next cycle text_out is all 0, busy=0 and no done pulse; a start after that processes the new message normally.
REQ-033 SHALL pass this check: pulse start during RUN with different text_in -> ignored; the result matches the first message.
